// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to CDB_WIDTH completed FU results per cycle and
// registers them onto the CDB lanes. Define CDB_RR_ARB_EN for round-robin, else fixed priority.
module cdb_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int CDB_WIDTH = 2,
  parameter int PRF_IDX_W = 6,
  parameter int ARF_IDX_W = 5,
  parameter int ROB_IDX_W = 5,
  parameter int DATA_W    = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [NUM_SRC-1:0]                  src_valid,
  output logic [NUM_SRC-1:0]                  src_ready,
  input  logic [NUM_SRC-1:0][PRF_IDX_W-1:0]   src_rd_phy,
  input  logic [NUM_SRC-1:0][ARF_IDX_W-1:0]   src_rd_arch,
  input  logic [NUM_SRC-1:0][ROB_IDX_W-1:0]   src_rob_id,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]      src_data,
  input  logic [NUM_SRC-1:0]                  src_regf_we,
  output logic [CDB_WIDTH-1:0]                cdb_valid,
  output logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0] cdb_rd_phy,
  output logic [CDB_WIDTH-1:0][ARF_IDX_W-1:0] cdb_rd_arch,
  output logic [CDB_WIDTH-1:0][ROB_IDX_W-1:0] cdb_rob_id,
  output logic [CDB_WIDTH-1:0][DATA_W-1:0]    cdb_data,
  output logic [CDB_WIDTH-1:0]                cdb_regf_we
);

  localparam int SRC_IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [SRC_IDX_W-1:0]                scan_start;
  logic [NUM_SRC-1:0]                  grant;
  logic [CDB_WIDTH-1:0]                lane_vld;
  logic [CDB_WIDTH-1:0][SRC_IDX_W-1:0] lane_sel;

  logic [CDB_WIDTH-1:0]                vld_p1;
  logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0] rd_phy_p1;
  logic [CDB_WIDTH-1:0][ARF_IDX_W-1:0] rd_arch_p1;
  logic [CDB_WIDTH-1:0][ROB_IDX_W-1:0] rob_id_p1;
  logic [CDB_WIDTH-1:0][DATA_W-1:0]    data_p1;
  logic [CDB_WIDTH-1:0]                regf_we_p1;

  // Source index reached after stepping offs positions from start, wrapping at NUM_SRC.
  function automatic logic [SRC_IDX_W-1:0] scan_idx(input logic [SRC_IDX_W-1:0] start,
                                                   input int offs);
    int sum;
    sum = int'(start) + offs;
    if (sum >= NUM_SRC) sum = sum - NUM_SRC;
    return SRC_IDX_W'(sum);
  endfunction

  // Stage p0: rotated scan; the k-th valid source found is steered to lane k.
  always_comb begin
    logic [SRC_IDX_W-1:0] idx;
    int                   cnt;
    grant    = '0;
    lane_vld = '0;
    lane_sel = '0;
    idx      = '0;
    cnt      = 0;
    for (int j = 0; j < NUM_SRC; j++) begin
      idx = scan_idx(scan_start, j);
      if (!rst && !flush && src_valid[idx] && cnt < CDB_WIDTH) begin
        grant[idx] = 1'b1;
        for (int k = 0; k < CDB_WIDTH; k++) begin
          if (k == cnt) begin
            lane_vld[k] = 1'b1;
            lane_sel[k] = idx;
          end
        end
        cnt = cnt + 1;
      end
    end
  end

  assign src_ready = grant;

`ifdef CDB_RR_ARB_EN
  logic [SRC_IDX_W-1:0] rr_ptr;
  logic [SRC_IDX_W-1:0] last_idx;

  function automatic logic [SRC_IDX_W-1:0] wrap_inc(input logic [SRC_IDX_W-1:0] i);
    return (i == SRC_IDX_W'(NUM_SRC - 1)) ? '0 : i + 1'b1;
  endfunction

  // Lanes fill in scan order, so the highest loaded lane holds the last granted source.
  always_comb begin
    last_idx = rr_ptr;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      if (lane_vld[k]) last_idx = lane_sel[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (lane_vld[0]) begin
      rr_ptr <= wrap_inc(last_idx);
    end
  end

  assign scan_start = rr_ptr;
`else
  assign scan_start = '0;
`endif

  // Stage p1: lane registers; a lane broadcasts for exactly the cycle after its grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= '0;
    end else begin
      vld_p1 <= lane_vld;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < CDB_WIDTH; k++) begin
      if (lane_vld[k]) begin
        rd_phy_p1[k]  <= src_rd_phy[lane_sel[k]];
        rd_arch_p1[k] <= src_rd_arch[lane_sel[k]];
        rob_id_p1[k]  <= src_rob_id[lane_sel[k]];
        data_p1[k]    <= src_data[lane_sel[k]];
        regf_we_p1[k] <= src_regf_we[lane_sel[k]];
      end
    end
  end

  assign cdb_valid   = vld_p1;
  assign cdb_rd_phy  = rd_phy_p1;
  assign cdb_rd_arch = rd_arch_p1;
  assign cdb_rob_id  = rob_id_p1;
  assign cdb_data    = data_p1;
  assign cdb_regf_we = regf_we_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; expectations follow CDB_RR_ARB_EN the same way the design does.
module tb_cdb_arbiter;
  localparam int NS = 4;
  localparam int CW = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic [NS-1:0]          src_valid;
  logic [NS-1:0]          src_ready;
  logic [NS-1:0][5:0]     src_rd_phy;
  logic [NS-1:0][4:0]     src_rd_arch;
  logic [NS-1:0][4:0]     src_rob_id;
  logic [NS-1:0][31:0]    src_data;
  logic [NS-1:0]          src_regf_we;
  logic [CW-1:0]          cdb_valid;
  logic [CW-1:0][5:0]     cdb_rd_phy;
  logic [CW-1:0][4:0]     cdb_rd_arch;
  logic [CW-1:0][4:0]     cdb_rob_id;
  logic [CW-1:0][31:0]    cdb_data;
  logic [CW-1:0]          cdb_regf_we;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(
    .NUM_SRC(NS), .CDB_WIDTH(CW), .PRF_IDX_W(6), .ARF_IDX_W(5), .ROB_IDX_W(5), .DATA_W(32)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_rd_phy(src_rd_phy), .src_rd_arch(src_rd_arch), .src_rob_id(src_rob_id),
    .src_data(src_data), .src_regf_we(src_regf_we),
    .cdb_valid(cdb_valid), .cdb_rd_phy(cdb_rd_phy), .cdb_rd_arch(cdb_rd_arch),
    .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data), .cdb_regf_we(cdb_regf_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lane(input string tag, input int k, input int s);
    chk({tag, "_vld"}, 64'(cdb_valid[k]), 64'(1'b1));
    chk({tag, "_phy"}, 64'(cdb_rd_phy[k]), 64'(6'(10 + s)));
    chk({tag, "_data"}, 64'(cdb_data[k]), 64'(32'hA000_0000 + 32'(s)));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_default_src(input int i);
    src_rd_phy[i]  = 6'(10 + i);
    src_rd_arch[i] = 5'(i + 1);
    src_rob_id[i]  = 5'(20 + i);
    src_data[i]    = 32'hA000_0000 + 32'(i);
    src_regf_we[i] = 1'(i);
  endtask

  logic [NS-1:0] exp_rdy [3];
  int            exp_l0  [3];
  int            exp_l1  [3];

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    src_valid = '1;
    for (int i = 0; i < NS; i++) set_default_src(i);

    // Reset holds grants and lanes off even with every source requesting.
    tick;
    chk("rst_vld_a", 64'(cdb_valid), 64'(2'b00));
    chk("rst_rdy_a", 64'(src_ready), 64'(4'b0000));
    tick;
    chk("rst_vld_b", 64'(cdb_valid), 64'(2'b00));
    chk("rst_rdy_b", 64'(src_ready), 64'(4'b0000));
    rst = 1'b0;
    src_valid = '0;
    tick;
    chk("idle_vld", 64'(cdb_valid), 64'(2'b00));

    // Four sources held until granted.
    src_valid = 4'b1111;
    #1 chk("s2_rdy0", 64'(src_ready), 64'(4'b0011));
    tick;
    chk_lane("s2_c1_l0", 0, 0);
    chk_lane("s2_c1_l1", 1, 1);
    src_valid = 4'b1100;
    #1 chk("s2_rdy1", 64'(src_ready), 64'(4'b1100));
    tick;
    chk_lane("s2_c2_l0", 0, 2);
    chk_lane("s2_c2_l1", 1, 3);
    src_valid = '0;
    #1 chk("s2_rdy2", 64'(src_ready), 64'(4'b0000));
    tick;
    chk("s2_c3_vld", 64'(cdb_valid), 64'(2'b00));

    // Single source 3, then sources 0 and 3.
    src_rd_phy[3] = 6'd7;
    src_valid = 4'b1000;
    #1 chk("s3_rdy0", 64'(src_ready), 64'(4'b1000));
    tick;
    chk("s3_l0_phy", 64'(cdb_rd_phy[0]), 64'(6'd7));
    chk("s3_vld", 64'(cdb_valid), 64'(2'b01));
    src_rd_phy[0] = 6'd9;
    src_valid = 4'b1001;
    #1 chk("s3_rdy1", 64'(src_ready), 64'(4'b1001));
    tick;
    chk("s3_wrap_l0", 64'(cdb_rd_phy[0]), 64'(6'd9));
    chk("s3_wrap_l1", 64'(cdb_rd_phy[1]), 64'(6'd7));
    chk("s3_wrap_vld", 64'(cdb_valid), 64'(2'b11));
    src_valid = '0;
    set_default_src(0);
    set_default_src(3);

    // Flush blocks grants for one cycle.
    src_valid = 4'b0110;
    flush = 1'b1;
    #1 chk("s4_rdy_fl", 64'(src_ready), 64'(4'b0000));
    tick;
    chk("s4_vld_fl", 64'(cdb_valid), 64'(2'b00));
    flush = 1'b0;
    #1 chk("s4_rdy_post", 64'(src_ready), 64'(4'b0110));
    tick;
    chk_lane("s4_l0", 0, 1);
    chk_lane("s4_l1", 1, 2);
    src_valid = '0;

    // Full payload carried unchanged, broadcast once.
    src_rd_phy[2] = 6'd33;
    src_rd_arch[2] = 5'd17;
    src_rob_id[2] = 5'd5;
    src_data[2] = 32'hDEAD_BEEF;
    src_regf_we[2] = 1'b1;
    src_valid = 4'b0100;
    #1 chk("s5_rdy", 64'(src_ready), 64'(4'b0100));
    tick;
    chk("s5_vld", 64'(cdb_valid), 64'(2'b01));
    chk("s5_phy", 64'(cdb_rd_phy[0]), 64'(6'd33));
    chk("s5_arch", 64'(cdb_rd_arch[0]), 64'(5'd17));
    chk("s5_rob", 64'(cdb_rob_id[0]), 64'(5'd5));
    chk("s5_data", 64'(cdb_data[0]), 64'(32'hDEAD_BEEF));
    chk("s5_we", 64'(cdb_regf_we[0]), 64'(1'b1));
    src_valid = '0;
    set_default_src(2);
    tick;
    chk("s5_nodup", 64'(cdb_valid), 64'(2'b00));

    // Pointer now sits past source 2: round-robin starts at 3, fixed priority at 0.
    src_valid = 4'b1111;
`ifdef CDB_RR_ARB_EN
    #1 chk("rr_rdy0", 64'(src_ready), 64'(4'b1001));
    tick;
    chk_lane("rr_c1_l0", 0, 3);
    chk_lane("rr_c1_l1", 1, 0);
    src_valid = 4'b0110;
    #1 chk("rr_rdy1", 64'(src_ready), 64'(4'b0110));
    tick;
    chk_lane("rr_c2_l0", 0, 1);
    chk_lane("rr_c2_l1", 1, 2);
    exp_rdy = '{4'b1001, 4'b0110, 4'b1001};
    exp_l0  = '{3, 1, 3};
    exp_l1  = '{0, 2, 0};
`else
    #1 chk("fp_rdy0", 64'(src_ready), 64'(4'b0011));
    tick;
    chk_lane("fp_c1_l0", 0, 0);
    chk_lane("fp_c1_l1", 1, 1);
    src_valid = 4'b1100;
    #1 chk("fp_rdy1", 64'(src_ready), 64'(4'b1100));
    tick;
    chk_lane("fp_c2_l0", 0, 2);
    chk_lane("fp_c2_l1", 1, 3);
    exp_rdy = '{4'b0011, 4'b0011, 4'b0011};
    exp_l0  = '{0, 0, 0};
    exp_l1  = '{1, 1, 1};
`endif

    // All sources continuously valid.
    src_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("s6_rdy%0d", c), 64'(src_ready), 64'(exp_rdy[c]));
      tick;
      chk_lane($sformatf("s6_c%0d_l0", c), 0, exp_l0[c]);
      chk_lane($sformatf("s6_c%0d_l1", c), 1, exp_l1[c]);
    end

    // Reset mid-stream (with flush overlapping) drops lanes and re-homes the scan.
    tick;
    chk("mr_pre_vld", 64'(cdb_valid), 64'(2'b11));
    rst = 1'b1;
    #1 chk("mr_rdy_a", 64'(src_ready), 64'(4'b0000));
    tick;
    chk("mr_vld_a", 64'(cdb_valid), 64'(2'b00));
    flush = 1'b1;
    #1 chk("mr_rdy_b", 64'(src_ready), 64'(4'b0000));
    tick;
    chk("mr_vld_b", 64'(cdb_valid), 64'(2'b00));
    rst = 1'b0;
    flush = 1'b0;
    #1 chk("mr_rdy_post", 64'(src_ready), 64'(4'b0011));
    tick;
    chk_lane("mr_l0", 0, 0);
    chk_lane("mr_l1", 1, 1);
    src_valid = '0;
    tick;
    chk("end_vld", 64'(cdb_valid), 64'(2'b00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
